// File: rtl/inference_scheduler.sv
// Inference sequencing controller: per-sample load/run/score loop
// with a restoring divider producing running accuracy.
module inference_scheduler #(
    parameter int out_rows       = 10,
    parameter int max_inputs     = 200,
    parameter int timeout_cycles = 4096,
    localparam int CW = $clog2(max_inputs + 1),
    localparam int DW = CW + 7,
    localparam int TW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1,
    localparam int KW = $clog2(DW + 1)
) (
    input  logic                clk,
    input  logic                rst_overall,
    input  logic                enable_inference,
    input  logic                upload_done,
    input  logic [CW-1:0]       num_samples,
    output logic                load_req,
    input  logic                input_loaded,
    input  logic                final_done,
    input  logic [out_rows-1:0] expected_value,
    input  logic [out_rows-1:0] final_out,
    output logic [out_rows-1:0] expected_output,
    output logic [out_rows-1:0] obtained_output,
    output logic [CW-1:0]       sample_count,
    output logic [CW-1:0]       correct_count,
    output logic [8:0]          accuracy,
    output logic                acc_valid,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_IN, RUN, SCORE, DIVIDE, NEXT, DONE, ERR
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] target;
    logic [TW-1:0] timer;
    logic [KW-1:0] div_cnt;
    logic [DW-1:0] dvd, quo, quo_nxt;
    logic [CW-1:0] rem, rem_nxt;
    logic [CW:0]   trial, diff;
    logic          fits, timeout_hit, abort, start, match, div_last;

    assign busy        = !(state inside {IDLE, DONE, ERR});
    assign done        = (state == DONE);
    assign timeout_err = (state == ERR);
    assign load_req    = (state == LOAD);
    assign abort       = busy && !enable_inference;
    assign start       = enable_inference && upload_done;
    assign timeout_hit = (timer == TW'(timeout_cycles - 1));
    assign match       = (expected_output == obtained_output);
    assign div_last    = (div_cnt == KW'(DW - 1));

    // One restoring-division step: shift in the next dividend bit
    always_comb begin
        trial   = {rem, dvd[DW-1]};
        diff    = trial - {1'b0, sample_count};
        fits    = (trial >= {1'b0, sample_count});
        rem_nxt = fits ? diff[CW-1:0] : trial[CW-1:0];
        quo_nxt = {quo[DW-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst_overall) state <= IDLE;
        else             state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = (num_samples == '0) ? DONE : LOAD;
            LOAD:    state_d = WAIT_IN;
            WAIT_IN: begin
                if (input_loaded)     state_d = RUN;
                else if (timeout_hit) state_d = ERR;
            end
            RUN: begin
                if (final_done)       state_d = SCORE;
                else if (timeout_hit) state_d = ERR;
            end
            SCORE:   state_d = DIVIDE;
            DIVIDE:  if (div_last) state_d = NEXT;
            NEXT:    state_d = (sample_count == target) ? DONE : LOAD;
            DONE:    if (!enable_inference) state_d = IDLE;
            ERR:     if (!enable_inference) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst_overall) begin
            target          <= '0;
            timer           <= '0;
            div_cnt         <= '0;
            dvd             <= '0;
            quo             <= '0;
            rem             <= '0;
            expected_output <= '0;
            obtained_output <= '0;
            sample_count    <= '0;
            correct_count   <= '0;
            accuracy        <= '0;
            acc_valid       <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (!abort) begin
                unique case (state)
                    IDLE: if (start) begin
                        target        <= num_samples;
                        sample_count  <= '0;
                        correct_count <= '0;
                        accuracy      <= '0;
                        timer         <= '0;
                    end
                    LOAD:    timer <= '0;
                    WAIT_IN: timer <= input_loaded ? '0 : timer + TW'(1);
                    RUN: begin
                        if (final_done) begin
                            expected_output <= expected_value;
                            obtained_output <= final_out;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    SCORE: begin
                        sample_count  <= sample_count + CW'(1);
                        correct_count <= correct_count + CW'(match);
                        dvd     <= DW'(correct_count + CW'(match)) * DW'(100);
                        rem     <= '0;
                        quo     <= '0;
                        div_cnt <= '0;
                    end
                    DIVIDE: begin
                        dvd     <= {dvd[DW-2:0], 1'b0};
                        rem     <= rem_nxt;
                        quo     <= quo_nxt;
                        div_cnt <= div_cnt + KW'(1);
                        if (div_last) begin
                            accuracy  <= (quo_nxt > DW'(511)) ? 9'h1ff
                                                              : quo_nxt[8:0];
                            acc_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler with randomized samples.
module tb_inference_scheduler;

    localparam int R  = 10;
    localparam int CW = 8;
    localparam int TO = 16;

    typedef struct {
        int acc;
        int sc;
        int cc;
    } exp_t;

    logic          clk = 0;
    logic          rst_overall = 1;
    logic          enable_inference = 0;
    logic          upload_done = 0;
    logic [CW-1:0] num_samples = '0;
    logic          load_req;
    logic          input_loaded = 0;
    logic          final_done = 0;
    logic [R-1:0]  expected_value = '0;
    logic [R-1:0]  final_out = '0;
    logic [R-1:0]  expected_output, obtained_output;
    logic [CW-1:0] sample_count, correct_count;
    logic [8:0]    accuracy;
    logic          acc_valid, busy, done, timeout_err;

    int   tests = 0;
    int   fails = 0;
    int   ms, mc;
    exp_t q[$];

    inference_scheduler #(
        .out_rows(R), .max_inputs(200), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .rst_overall(rst_overall),
        .enable_inference(enable_inference), .upload_done(upload_done),
        .num_samples(num_samples), .load_req(load_req),
        .input_loaded(input_loaded), .final_done(final_done),
        .expected_value(expected_value), .final_out(final_out),
        .expected_output(expected_output),
        .obtained_output(obtained_output),
        .sample_count(sample_count), .correct_count(correct_count),
        .accuracy(accuracy), .acc_valid(acc_valid), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every accuracy update must match the next queued expectation
    always @(negedge clk) begin
        if (acc_valid) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_acc_valid: got acc %0d expected none",
                         accuracy);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (accuracy != e.acc || sample_count != e.sc ||
                    correct_count != e.cc) begin
                    fails++;
                    $display("FAIL acc_update: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             accuracy, sample_count, correct_count,
                             e.acc, e.sc, e.cc);
                end
            end
        end
    end

    task automatic wait_load();
        int n = 0;
        while (!load_req && n < 200) begin
            tick();
            n++;
        end
        chk("load_req_seen", load_req, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic set_labels(bit m);
        logic [R-1:0] lab;
        lab = R'(1) << $urandom_range(0, R - 1);
        expected_value = lab;
        final_out = m ? lab : (lab ^ R'($urandom_range(1, 1023)));
    endtask

    task automatic do_sample(bit m, int d1, int d2);
        wait_load();
        repeat (d1) tick();
        input_loaded = 1;
        tick();
        input_loaded = 0;
        repeat (d2) tick();
        set_labels(m);
        final_done = 1;
        ms++;
        mc += int'(m);
        q.push_back('{acc: (mc * 100) / ms, sc: ms, cc: mc});
        tick();
        final_done = 0;
    endtask

    task automatic begin_run(int n);
        ms = 0;
        mc = 0;
        num_samples = CW'(n);
        enable_inference = 1;
        upload_done = 1;
        tick();
    endtask

    task automatic end_run();
        enable_inference = 0;
        tick();
        tick();
    endtask

    task automatic run(int n, logic [7:0] mm, bit rnd);
        bit m;
        begin_run(n);
        num_samples = CW'($urandom_range(0, 200));
        if (rnd) upload_done = 0;
        for (int i = 0; i < n; i++) begin
            m = rnd ? 1'($urandom_range(0, 1)) : mm[i];
            do_sample(m, $urandom_range(1, 6), $urandom_range(0, 6));
        end
        wait_done();
        chk("run_sample_count", sample_count, n);
        chk("run_correct_count", correct_count, mc);
        chk("run_accuracy", accuracy, (mc * 100) / ms);
        chk("run_busy", busy, 0);
        chk("sb_drained", q.size(), 0);
        end_run();
    endtask

    initial begin
        tick();
        tick();
        rst_overall = 0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_load_req", load_req, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_correct_count", correct_count, 0);
        chk("rst_accuracy", accuracy, 0);
        chk("rst_expected_output", expected_output, 0);
        chk("rst_obtained_output", obtained_output, 0);

        // Basic: matches on samples 0,1,3 -> 100,100,66,75
        run(4, 8'b0000_1011, 0);
        chk("basic_accuracy", accuracy, 75);
        chk("basic_correct", correct_count, 3);

        for (int r = 0; r < 6; r++) run($urandom_range(1, 6), 8'h00, 1);

        // Zero samples
        begin_run(0);
        chk("zero_done", done, 1);
        chk("zero_load_req", load_req, 0);
        tick();
        chk("zero_load_req_later", load_req, 0);
        chk("zero_sample_count", sample_count, 0);
        end_run();

        // Timeout in WAIT_IN
        begin
            int cyc = -1;
            begin_run(1);
            chk("to_load_req", load_req, 1);
            tick();
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (timeout_err) begin
                    cyc = i;
                    break;
                end
            end
            chk("to_cycles", cyc, TO);
            chk("to_busy", busy, 0);
            tick();
            chk("to_sticky", timeout_err, 1);
            end_run();
            begin_run(1);
            chk("to_cleared", timeout_err, 0);
            end_run();
        end

        // Abort during second sample's division
        begin_run(2);
        do_sample(1, 2, 1);
        wait_load();
        tick();
        input_loaded = 1;
        tick();
        input_loaded = 0;
        set_labels(0);
        final_done = 1;
        tick();
        final_done = 0;
        tick();
        tick();
        enable_inference = 0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_accuracy", accuracy, 100);
        chk("abort_sample_count", sample_count, 2);
        chk("abort_correct_count", correct_count, 1);
        repeat (20) tick();
        chk("abort_sb_empty", q.size(), 0);

        // Stray final_done in WAIT_IN, then simultaneous pulses
        begin_run(1);
        wait_load();
        tick();
        set_labels(0);
        final_done = 1;
        tick();
        final_done = 0;
        tick();
        chk("stray_busy", busy, 1);
        chk("stray_sample_count", sample_count, 0);
        set_labels(0);
        input_loaded = 1;
        final_done = 1;
        tick();
        input_loaded = 0;
        final_done = 0;
        repeat (3) tick();
        chk("overlap_dropped", sample_count, 0);
        set_labels(1);
        final_done = 1;
        ms++;
        mc++;
        q.push_back('{acc: 100, sc: 1, cc: 1});
        tick();
        final_done = 0;
        chk("overlap_captured", obtained_output, expected_value);
        wait_done();
        chk("overlap_accuracy", accuracy, 100);
        end_run();

        // Reset while in RUN
        begin_run(1);
        wait_load();
        tick();
        input_loaded = 1;
        tick();
        input_loaded = 0;
        rst_overall = 1;
        tick();
        rst_overall = 0;
        chk("rrst_busy", busy, 0);
        chk("rrst_expected_output", expected_output, 0);
        chk("rrst_obtained_output", obtained_output, 0);
        chk("rrst_sample_count", sample_count, 0);
        chk("rrst_accuracy", accuracy, 0);
        upload_done = 0;
        repeat (5) tick();
        chk("rrst_no_upload_busy", busy, 0);
        chk("rrst_no_upload_load", load_req, 0);
        end_run();

        chk("final_sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
